// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : SVGA 800x600@60 timing constants and the D1 control struct.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int DFLT_H_ACTIVE = 800;
  localparam int DFLT_H_FP     = 40;
  localparam int DFLT_H_SYNC   = 128;
  localparam int DFLT_H_BP     = 88;
  localparam int DFLT_V_ACTIVE = 600;
  localparam int DFLT_V_FP     = 1;
  localparam int DFLT_V_SYNC   = 4;
  localparam int DFLT_V_BP     = 23;

  localparam int H_TOTAL    = DFLT_H_ACTIVE + DFLT_H_FP + DFLT_H_SYNC + DFLT_H_BP;
  localparam int V_TOTAL    = DFLT_V_ACTIVE + DFLT_V_FP + DFLT_V_SYNC + DFLT_V_BP;
  localparam int VRAM_DEPTH = DFLT_H_ACTIVE * DFLT_V_ACTIVE;

  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;
  localparam int ADDR_W  = 20;

  localparam logic [11:0] FG_AMBER = 12'hFB0;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic first;
  } vga_ctl_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_counter
// Purpose  : Horizontal/vertical scan counters with active/sync/first decode.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DFLT_H_ACTIVE,
  parameter int H_FP     = DFLT_H_FP,
  parameter int H_SYNC   = DFLT_H_SYNC,
  parameter int H_BP     = DFLT_H_BP,
  parameter int V_ACTIVE = DFLT_V_ACTIVE,
  parameter int V_FP     = DFLT_V_FP,
  parameter int V_SYNC   = DFLT_V_SYNC,
  parameter int V_BP     = DFLT_V_BP
) (
  input  logic               clk,
  input  logic               rst,
  output vga_ctl_t           o_ctl,
  output logic [H_CNT_W-1:0] o_h_cnt,
  output logic [V_CNT_W-1:0] o_v_cnt
);

  localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_CNT_W-1:0] H_LAST   = H_CNT_W'(LINE_LEN - 1);
  localparam logic [H_CNT_W-1:0] H_ACT    = H_CNT_W'(H_ACTIVE);
  localparam logic [H_CNT_W-1:0] HS_START = H_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [H_CNT_W-1:0] HS_END   = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_CNT_W-1:0] V_LAST   = V_CNT_W'(FRAME_LINES - 1);
  localparam logic [V_CNT_W-1:0] V_ACT    = V_CNT_W'(V_ACTIVE);
  localparam logic [V_CNT_W-1:0] VS_START = V_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [V_CNT_W-1:0] VS_END   = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_CNT_W-1:0] r_h_cnt;
  logic [V_CNT_W-1:0] r_v_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  always_comb begin
    o_ctl       = '0;
    o_ctl.de    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    o_ctl.hs    = (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
    o_ctl.vs    = (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);
    o_ctl.first = (r_h_cnt == '0) && (r_v_cnt == '0);
  end

  assign o_h_cnt = r_h_cnt;
  assign o_v_cnt = r_v_cnt;

endmodule
`default_nettype wire

// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : vga_scanout
// Purpose  : SVGA scan-out: VRAM read addressing and 2-stage sync/RGB pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scanout
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE = DFLT_H_ACTIVE,
  parameter int          H_FP     = DFLT_H_FP,
  parameter int          H_SYNC   = DFLT_H_SYNC,
  parameter int          H_BP     = DFLT_H_BP,
  parameter int          V_ACTIVE = DFLT_V_ACTIVE,
  parameter int          V_FP     = DFLT_V_FP,
  parameter int          V_SYNC   = DFLT_V_SYNC,
  parameter int          V_BP     = DFLT_V_BP,
  parameter logic        SYNC_POL = 1'b1,
  parameter logic [11:0] FG_RGB   = FG_AMBER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixel_data,
  output logic [19:0] raddr,
  output logic        hsync,
  output logic        vsync,
  output logic        video_de,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        frame_start
);

  localparam logic [H_CNT_W-1:0] H_LAST_PX = H_CNT_W'(H_ACTIVE - 1);
  localparam logic [V_CNT_W-1:0] V_LAST_PX = V_CNT_W'(V_ACTIVE - 1);

  vga_ctl_t           w_ctl_f;
  logic [H_CNT_W-1:0] w_h_cnt;
  logic [V_CNT_W-1:0] w_v_cnt;
  logic               w_last_px;
  logic [11:0]        w_rgb;

  vga_ctl_t           r_ctl_d1;
  logic [ADDR_W-1:0]  r_raddr;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_de;
  logic               r_first;
  logic [11:0]        r_rgb;

  vga_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk     (clk),
    .rst     (rst),
    .o_ctl   (w_ctl_f),
    .o_h_cnt (w_h_cnt),
    .o_v_cnt (w_v_cnt)
  );

  // The last visible dot is where raddr holds the final VRAM address, so the
  // wrap is decided from the counters instead of a wide address compare.
  assign w_last_px = (w_h_cnt == H_LAST_PX) && (w_v_cnt == V_LAST_PX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_raddr <= '0;
    end else if (w_ctl_f.de) begin
      r_raddr <= w_last_px ? '0 : r_raddr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctl_d1 <= '0;
    end else begin
      r_ctl_d1 <= w_ctl_f;
    end
  end

  assign w_rgb = (r_ctl_d1.de && pixel_data) ? FG_RGB : 12'h000;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_de    <= 1'b0;
      r_first <= 1'b0;
      r_rgb   <= 12'h000;
    end else begin
      r_hsync <= SYNC_POL ? r_ctl_d1.hs : ~r_ctl_d1.hs;
      r_vsync <= SYNC_POL ? r_ctl_d1.vs : ~r_ctl_d1.vs;
      r_de    <= r_ctl_d1.de;
      r_first <= r_ctl_d1.first;
      r_rgb   <= w_rgb;
    end
  end

  assign raddr       = r_raddr;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_de    = r_de;
  assign frame_start = r_first;
  assign red         = r_rgb[11:8];
  assign green       = r_rgb[7:4];
  assign blue        = r_rgb[3:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scanout
// Purpose  : Directed bench for vga_scanout (full SVGA and small-timing builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst      = 1'b1;
  logic pd_small = 1'b1;
  logic pd_full  = 1'b0;

  logic [19:0] f_raddr, s_raddr, n_raddr;
  logic        f_hs, f_vs, f_de, f_fs;
  logic        s_hs, s_vs, s_de, s_fs;
  logic        n_hs, n_vs, n_de, n_fs;
  logic [3:0]  f_r, f_g, f_b, s_r, s_g, s_b, n_r, n_g, n_b;

  int errors = 0;
  int checks = 0;
  int k      = 0;
  int de_cnt = 0;
  int fs_cnt = 0;
  int hs_hi  = 0;

  vga_scanout u_full (
    .clk(clk), .rst(rst), .pixel_data(pd_full), .raddr(f_raddr),
    .hsync(f_hs), .vsync(f_vs), .video_de(f_de),
    .red(f_r), .green(f_g), .blue(f_b), .frame_start(f_fs)
  );

  // Small frame: 15 clocks/line (hs 10..12), 8 lines/frame (vs lines 5..6), 8x4 visible.
  vga_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) u_small (
    .clk(clk), .rst(rst), .pixel_data(pd_small), .raddr(s_raddr),
    .hsync(s_hs), .vsync(s_vs), .video_de(s_de),
    .red(s_r), .green(s_g), .blue(s_b), .frame_start(s_fs)
  );

  vga_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) u_neg (
    .clk(clk), .rst(rst), .pixel_data(pd_small), .raddr(n_raddr),
    .hsync(n_hs), .vsync(n_vs), .video_de(n_de),
    .red(n_r), .green(n_g), .blue(n_b), .frame_start(n_fs)
  );

  // VRAM model for the full build: ram[a] = a[0], one-cycle read latency.
  always @(posedge clk) pd_full <= f_raddr[0];

  task automatic tick();
    @(negedge clk);
    k++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d: observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // Expected {de,hs,vs,fs,rgb} of a small build k clocks after reset release.
  function automatic logic [15:0] exp_out(input int kk, input logic pol);
    int p, h, v;
    logic de, hs, vs, fs;
    if (kk < 2) return {1'b0, ~pol, ~pol, 1'b0, 12'h000};
    p  = (kk - 2) % 120;
    h  = p % 15;
    v  = p / 15;
    de = (h < 8) && (v < 4);
    hs = (h >= 10) && (h < 13);
    vs = (v >= 5) && (v < 7);
    fs = (p == 0);
    return {de, pol ? hs : ~hs, pol ? vs : ~vs, fs, de ? 12'hFB0 : 12'h000};
  endfunction

  // Expected raddr of the small build with counters at position kk.
  function automatic logic [31:0] exp_addr(input int kk);
    int p, h, v;
    p = kk % 120;
    h = p % 15;
    v = p / 15;
    if (v >= 4) return 0;
    if (h < 8)  return 32'(v * 8 + h);
    if (v == 3) return 0;
    return 32'((v + 1) * 8);
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_full_ctl",   {28'd0, f_de, f_hs, f_vs, f_fs}, 32'h0);
    chk("rst_full_rgb",   {20'd0, f_r, f_g, f_b}, 32'h0);
    chk("rst_full_raddr", {12'd0, f_raddr}, 32'h0);
    chk("rst_small_ctl",  {28'd0, s_de, s_hs, s_vs, s_fs}, 32'h0);
    chk("rst_neg_sync",   {30'd0, n_hs, n_vs}, 32'h3);
    chk("rst_neg_de_rgb", {19'd0, n_de, n_fs, n_r, n_g, n_b}, 32'h0);

    rst = 1'b0;
    k   = 0;
    for (int i = 0; i < 241; i++) begin
      tick();
      chk("small_out",   {16'd0, s_de, s_hs, s_vs, s_fs, s_r, s_g, s_b}, {16'd0, exp_out(k, 1'b1)});
      chk("neg_out",     {16'd0, n_de, n_hs, n_vs, n_fs, n_r, n_g, n_b}, {16'd0, exp_out(k, 1'b0)});
      chk("small_raddr", {12'd0, s_raddr}, exp_addr(k));
      if (k >= 2 && k <= 121 && s_de) de_cnt++;
      if (s_fs) fs_cnt++;
      if (k == 1) chk("full_pre_de", {30'd0, f_de, f_fs}, 32'h0);
      if (k == 2) chk("full_first_de", {30'd0, f_de, f_fs}, 32'h3);
    end
    chk("small_de_per_frame", de_cnt, 32);
    chk("small_fs_count", fs_cnt, 2);

    while (k < 5315) begin
      tick();
      case (k)
        799:  chk("full_raddr_eol",    {12'd0, f_raddr}, 799);
        900:  chk("full_raddr_hblank", {12'd0, f_raddr}, 800);
        841:  chk("full_hs_pre",   {31'd0, f_hs}, 0);
        842:  chk("full_hs_rise",  {31'd0, f_hs}, 1);
        969:  chk("full_hs_last",  {31'd0, f_hs}, 1);
        970:  chk("full_hs_fall",  {31'd0, f_hs}, 0);
        1897: chk("full_hs_pre2",  {31'd0, f_hs}, 0);
        1898: chk("full_hs_rise2", {31'd0, f_hs}, 1);
        5287: chk("full_raddr_r5c7", {12'd0, f_raddr}, 4007);
        5289: chk("full_px_r5c7", {19'd0, f_de, f_r, f_g, f_b}, {19'd0, 1'b1, 12'hFB0});
        5290: chk("full_px_r5c8", {19'd0, f_de, f_r, f_g, f_b}, {19'd0, 1'b1, 12'h000});
        default: ;
      endcase
      if (k >= 842 && k < 1898 && f_hs) hs_hi++;
    end
    chk("full_hs_width", hs_hi, 128);
    chk("small_pre_rst_de",    {31'd0, s_de}, 1);
    chk("small_pre_rst_raddr", {12'd0, s_raddr}, 21);

    rst = 1'b1;
    tick();
    chk("mid_rst_small", {15'd0, s_de, s_hs, s_vs, s_fs, s_r, s_g, s_b, 1'b0}, 32'h0);
    chk("mid_rst_raddr", {12'd0, s_raddr}, 0);
    chk("mid_rst_neg",   {30'd0, n_hs, n_vs}, 32'h3);
    chk("mid_rst_full",  {12'd0, f_raddr}, 0);

    rst = 1'b0;
    tick();
    chk("rel1_small",  {30'd0, s_de, s_fs}, 0);
    chk("rel1_raddr",  {12'd0, s_raddr}, 1);
    tick();
    chk("rel2_small",  {18'd0, s_de, s_fs, s_r, s_g, s_b}, {18'd0, 2'b11, 12'hFB0});
    chk("rel2_neg_de", {31'd0, n_de}, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rel_small_sync_idle", {30'd0, s_hs, s_vs}, 32'h0);
      chk("rel_neg_sync_idle",   {30'd0, n_hs, n_vs}, 32'h3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
